// File: rtl/stage_insert_responder.sv
// Stage-side insert responder: a hashed read-modify-write of the per-bucket counter and max latency.
// Optional macro STAGE_INSERT_CLEAR_EN adds clear_i and a CLEAR state that zeroes both arrays.
module stage_insert_responder #(
    parameter int unsigned     HW   = 10,
    parameter int unsigned     DW   = 64,
    parameter int unsigned     CW   = 16,
    parameter int unsigned     LW   = 8,
    parameter logic [DW-1:0]   SEED = DW'(64'h9E3779B97F4A7C15)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          insert_i,
`ifdef STAGE_INSERT_CLEAR_EN
    input  logic          clear_i,
`endif
    input  logic [DW-1:0] id_i,
    input  logic [DW-1:0] latency_i,
    input  logic [DW-1:0] freq_th_i,
    output logic          insert_end_o,
    output logic          busy_o,
    output logic          pass_o,
    output logic [HW-1:0] index_o,
    output logic [CW-1:0] count_o,
    output logic [LW-1:0] max_lat_o
);

    localparam int unsigned DEPTH = 1 << HW;
    localparam int unsigned NS    = (DW + HW - 1) / HW;
    localparam int unsigned KW    = NS * HW;

    typedef enum logic [2:0] {
        IDLE,
        HASH,
        READ,
        MODIFY,
        WRITE,
        DONE
`ifdef STAGE_INSERT_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    state_t          state_q, state_d;

    logic [DW-1:0]   id_q;
    logic [LW-1:0]   lat_q;
    logic [DW-1:0]   thr_q;
    logic [HW-1:0]   hash_c;
    logic [KW-1:0]   key_pad;
    logic [CW-1:0]   rd_cnt_q, new_cnt_c, new_cnt_q;
    logic [LW-1:0]   rd_lat_q, new_lat_c, new_lat_q;
    logic [HW-1:0]   clr_addr_q;
    logic            mem_we;
    logic [HW-1:0]   mem_addr;
    logic [CW-1:0]   mem_cnt;
    logic [LW-1:0]   mem_lat;

    logic [CW-1:0]   cnt_mem [DEPTH];
    logic [LW-1:0]   lat_mem [DEPTH];

    // Only the low LW bits of the latency are ever stored.
    logic            unused_lat;
    assign unused_lat = &{1'b0, latency_i[DW-1:LW]};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef STAGE_INSERT_CLEAR_EN
                if (clear_i) begin
                    state_d = CLEAR;
                end else
`endif
                if (insert_i) begin
                    state_d = HASH;
                end
            end
            HASH:   state_d = READ;
            READ:   state_d = MODIFY;
            MODIFY: state_d = WRITE;
            WRITE:  state_d = DONE;
            DONE:   state_d = IDLE;
`ifdef STAGE_INSERT_CLEAR_EN
            CLEAR:  if (&clr_addr_q) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Index = XOR fold of HW-bit slices of the seeded key, top slice zero-padded
    always_comb begin
        key_pad = KW'(id_q ^ SEED);
        hash_c  = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            hash_c = hash_c ^ key_pad[i*HW +: HW];
        end
    end

    // Saturating increment and running max of the truncated latency
    always_comb begin
        new_cnt_c = (&rd_cnt_q) ? rd_cnt_q : rd_cnt_q + CW'(1);
        new_lat_c = (lat_q > rd_lat_q) ? lat_q : rd_lat_q;
    end

    // Shared RAM write port: insert write-back or clear sweep
    always_comb begin
        mem_we   = (state_q == WRITE);
        mem_addr = index_o;
        mem_cnt  = new_cnt_q;
        mem_lat  = new_lat_q;
`ifdef STAGE_INSERT_CLEAR_EN
        if (state_q == CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = clr_addr_q;
            mem_cnt  = '0;
            mem_lat  = '0;
        end
`endif
    end

    // Bucket arrays: synchronous read, single write, contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            cnt_mem[mem_addr] <= mem_cnt;
            lat_mem[mem_addr] <= mem_lat;
        end
        if (state_q == READ) begin
            rd_cnt_q <= cnt_mem[index_o];
            rd_lat_q <= lat_mem[index_o];
        end
    end

    // Request capture, pipeline registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q         <= '0;
            lat_q        <= '0;
            thr_q        <= '0;
            new_cnt_q    <= '0;
            new_lat_q    <= '0;
            clr_addr_q   <= '0;
            insert_end_o <= 1'b0;
            busy_o       <= 1'b0;
            pass_o       <= 1'b0;
            index_o      <= '0;
            count_o      <= '0;
            max_lat_o    <= '0;
        end else begin
            busy_o       <= (state_d != IDLE);
            insert_end_o <= (state_q == DONE);
            clr_addr_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (state_d == HASH) begin
                        id_q  <= id_i;
                        lat_q <= latency_i[LW-1:0];
                        thr_q <= freq_th_i;
                    end
                end
                HASH: index_o <= hash_c;
                MODIFY: begin
                    new_cnt_q <= new_cnt_c;
                    new_lat_q <= new_lat_c;
                end
                WRITE: begin
                    count_o   <= new_cnt_q;
                    max_lat_o <= new_lat_q;
                    pass_o    <= (DW'(new_cnt_q) >= thr_q);
                end
`ifdef STAGE_INSERT_CLEAR_EN
                CLEAR: clr_addr_q <= clr_addr_q + HW'(1);
`endif
                default: ;
            endcase
        end
    end

endmodule
